mem_bus_arbiter: RTL

- Shares the single 21-bit-address / 16-bit-data memory bus between the instruction-fetch port (read-only) and the data port (read/write).
- Sequences each access against the memory's needWait handshake.
- Inserts the mandatory one-cycle strobe-low recovery between accesses so the memory's completion flag clears.
- Sits between the CPU fetch/load-store units and the ROM/RAM devices.

---
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one 21-bit address / 16-bit data memory bus between a read-only
// instruction-fetch port and a read/write data port. Each access is run
// against the memory's needWait handshake. After every access the strobes
// stay low for one cycle, so the memory's completion flag can clear.
//
// Configuration:
//   TIMEOUT_CYCLES - BUSY cycles allowed before an access is aborted (1..65535)
//   DATA_FIRST     - tie winner: 1 = data port, 0 = fetch port
//   `MEM_ARB_ROUND_ROBIN_EN - when defined, a tie goes to the port that was
//                             not served last, and DATA_FIRST is ignored
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   if_addr_i, if_re_i         fetch request (held until if_ack_o)
//   if_needWait_o, if_ack_o    fetch stall / one-cycle completion pulse
//   if_rdata_o                 last fetched word
//   dm_addr_i, dm_re_i,        data request (a write wins over a read)
//   dm_we_i, dm_wdata_i
//   dm_needWait_o, dm_ack_o    data stall / one-cycle completion pulse
//   dm_rdata_o                 last data word read
//   err_o                      pulses together with the ack of an aborted access
//   mem_addr_o, mem_re_o,      registered bus address and strobes
//   mem_we_o
//   mem_needWait_i             memory busy for the current strobe
//   mem_data_io                driven with the write data only while mem_we_o is high
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          DATA_FIRST     = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [20:0] if_addr_i,
   input  logic        if_re_i,
   output logic        if_needWait_o,
   output logic        if_ack_o,
   output logic [15:0] if_rdata_o,
   input  logic [20:0] dm_addr_i,
   input  logic        dm_re_i,
   input  logic        dm_we_i,
   input  logic [15:0] dm_wdata_i,
   output logic        dm_needWait_o,
   output logic        dm_ack_o,
   output logic [15:0] dm_rdata_o,
   output logic        err_o,
   output logic [20:0] mem_addr_o,
   output logic        mem_re_o,
   output logic        mem_we_o,
   input  logic        mem_needWait_i,
   inout  wire  [15:0] mem_data_io
);

   typedef enum logic [1:0] {StIdle, StBusy, StRecover} state_t;

   localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

   state_t      r_state;
   logic        r_owner_dm;
   logic [20:0] r_mem_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_cnt;
   logic [15:0] r_if_rdata;
   logic [15:0] r_dm_rdata;
   logic        r_mem_re;
   logic        r_mem_we;
   logic        r_if_ack;
   logic        r_dm_ack;
   logic        r_err;

   logic        w_if_req;
   logic        w_dm_req;
   logic        w_prio_dm;
   logic        w_grant;
   logic        w_grant_dm;
   logic [15:0] w_cnt_inc;
   logic        w_timeout;

   always_comb begin
      // An ack is high only in RECOVER. Masking with it stops the port being
      // acked from winning again in that same cycle.
      w_if_req = if_re_i & ~r_if_ack;
      w_dm_req = (dm_re_i | dm_we_i) & ~r_dm_ack;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // The owner register records the last port granted (it resets to fetch).
      w_prio_dm = ~r_owner_dm;
`else
      w_prio_dm = DATA_FIRST;
`endif
      w_grant    = w_if_req | w_dm_req;
      w_grant_dm = w_dm_req & (~w_if_req | w_prio_dm);
      w_cnt_inc  = r_cnt + 16'd1;
      w_timeout  = (w_cnt_inc >= LP_TIMEOUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_owner_dm <= 1'b0;
         r_mem_addr <= '0;
         r_wdata    <= '0;
         r_cnt      <= '0;
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
         r_mem_re   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_if_ack   <= 1'b0;
         r_dm_ack   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_if_ack <= 1'b0;
         r_dm_ack <= 1'b0;
         r_err    <= 1'b0;
         unique case (r_state)
            StIdle, StRecover: begin
               if (w_grant) begin
                  r_state    <= StBusy;
                  r_owner_dm <= w_grant_dm;
                  r_mem_addr <= w_grant_dm ? dm_addr_i : if_addr_i;
                  r_wdata    <= dm_wdata_i;
                  r_mem_re   <= ~(w_grant_dm & dm_we_i);
                  r_mem_we   <= w_grant_dm & dm_we_i;
                  r_cnt      <= '0;
               end else begin
                  r_state <= StIdle;
               end
            end
            StBusy: begin
               r_cnt <= w_cnt_inc;
               if (!mem_needWait_i || w_timeout) begin
                  // Read data is captured only on a real completion; an abort
                  // leaves the rdata registers unchanged.
                  if (!mem_needWait_i && !r_mem_we) begin
                     if (r_owner_dm) begin
                        r_dm_rdata <= mem_data_io;
                     end else begin
                        r_if_rdata <= mem_data_io;
                     end
                  end
                  r_if_ack <= ~r_owner_dm;
                  r_dm_ack <= r_owner_dm;
                  r_err    <= mem_needWait_i;
                  r_mem_re <= 1'b0;
                  r_mem_we <= 1'b0;
                  r_state  <= StRecover;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign if_needWait_o = if_re_i & ~r_if_ack;
   assign dm_needWait_o = (dm_re_i | dm_we_i) & ~r_dm_ack;
   assign if_ack_o      = r_if_ack;
   assign dm_ack_o      = r_dm_ack;
   assign if_rdata_o    = r_if_rdata;
   assign dm_rdata_o    = r_dm_rdata;
   assign err_o         = r_err;
   assign mem_addr_o    = r_mem_addr;
   assign mem_re_o      = r_mem_re;
   assign mem_we_o      = r_mem_we;
   assign mem_data_io   = r_mem_we ? r_wdata : 16'hzzzz;

endmodule
